pe_start_sched: RTL and testbench



---
 rtl/pe_start_sched.sv | 109 ++++++++++
 tb/tb_pe_start_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_start_sched.sv
// Wavefront start scheduler: issues cfg_beats advance enables to a chain of PEs,
// with stage i enabled one unstalled cycle after stage i-1, then drains and pulses done.
module pe_start_sched #(
   parameter int NUM_PE    = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CNT_WIDTH-1:0] cfg_beats,
   input  logic                 stall,
   input  logic                 abort,
   output logic [NUM_PE-1:0]    ap_start,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] beat_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state, state_nxt;
   logic [NUM_PE-1:0]    sh, sh_nxt, sh_in;
   logic [CNT_WIDTH-1:0] remaining, remaining_nxt;
   logic [CNT_WIDTH-1:0] beat_cnt_nxt;
   logic                 active;
   logic                 advance;

   // The head of the wavefront is fed by RUN; in DRAIN zeros shift in behind it.
   assign sh_in   = {sh[NUM_PE-2:0], state == RUN};
   assign active  = (state == RUN) || (state == DRAIN);
   assign advance = active && !stall && !abort;

   // In the DRAIN empty-check cycle sh_in is already all zeros, so no extra gating.
   assign ap_start  = advance ? sh_in : '0;
   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_comb begin
      // NOTE: every target gets a default first so no path can leave it unassigned and infer a latch.
      state_nxt     = state;
      sh_nxt        = sh;
      remaining_nxt = remaining;
      beat_cnt_nxt  = beat_cnt;

      case (state)
         IDLE: begin
            if (cfg_valid) begin
               remaining_nxt = cfg_beats;
               beat_cnt_nxt  = '0;
               sh_nxt        = '0;
               state_nxt     = (cfg_beats != '0) ? RUN : DONE;
            end
         end

         RUN: begin
            if (abort) begin
               sh_nxt    = '0;
               state_nxt = IDLE;
            end else if (!stall) begin
               sh_nxt        = sh_in;
               remaining_nxt = remaining - CNT_ONE;
               beat_cnt_nxt  = beat_cnt + CNT_ONE;
               if (remaining == CNT_ONE) state_nxt = DRAIN;
            end
         end

         DRAIN: begin
            // Emptiness is checked even while stalled: an empty chain has nothing to freeze.
            if (abort) begin
               sh_nxt    = '0;
               state_nxt = IDLE;
            end else if (sh[NUM_PE-2:0] == '0) begin
               state_nxt = DONE;
            end else if (!stall) begin
               sh_nxt = sh_in;
            end
         end

         DONE: state_nxt = IDLE;

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         sh        <= '0;
         remaining <= '0;
         beat_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values together.
         state     <= state_nxt;
         sh        <= sh_nxt;
         remaining <= remaining_nxt;
         beat_cnt  <= beat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_pe_start_sched.sv
// Self-checking bench for pe_start_sched: per-cycle expected outputs are queued
// from a wavefront model and popped against the DUT at each falling edge.
module tb_pe_start_sched;

   localparam int NUM_PE    = 4;
   localparam int CNT_WIDTH = 16;

   // Record layout: {ap_start, done, cfg_ready, busy}
   typedef logic [NUM_PE+2:0] rec_t;
   localparam rec_t REC_IDLE = {{NUM_PE{1'b0}}, 3'b010};
   localparam rec_t REC_BUSY = {{NUM_PE{1'b0}}, 3'b001};
   localparam rec_t REC_DONE = {{NUM_PE{1'b0}}, 3'b101};

   logic                 clk;
   logic                 reset;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CNT_WIDTH-1:0] cfg_beats;
   logic                 stall;
   logic                 abort;
   logic [NUM_PE-1:0]    ap_start;
   logic                 busy;
   logic                 done;
   logic [CNT_WIDTH-1:0] beat_cnt;

   rec_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   pe_start_sched #(.NUM_PE(NUM_PE), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_beats (cfg_beats),
      .stall     (stall),
      .abort     (abort),
      .ap_start  (ap_start),
      .busy      (busy),
      .done      (done),
      .beat_cnt  (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected records from the accept cycle through DONE (or through the abort cycle).
   // PE i is enabled on unstalled slots u = i+1 .. i+b; the empty check follows the last slot.
   function automatic void push_job(input int b, input logic [63:0] smask, input int abort_at);
      int                u = 0;
      int                c = 1;
      logic [NUM_PE-1:0] ap;
      sb.push_back(REC_IDLE);
      if (b != 0) begin
         while (u < b + NUM_PE - 1) begin
            if (c == abort_at) begin
               sb.push_back(REC_BUSY);
               return;
            end
            ap = '0;
            if (!smask[c]) begin
               u++;
               for (int i = 0; i < NUM_PE; i++)
                  if ((u - 1 - i >= 0) && (u - 1 - i < b)) ap[i] = 1'b1;
            end
            sb.push_back({ap, 3'b001});
            c++;
         end
         sb.push_back(REC_BUSY);
      end
      sb.push_back(REC_DONE);
   endfunction

   task automatic test_reset();
      reset     = 1'b0;
      cfg_valid = 1'b1;
      cfg_beats = 16'd7;
      stall     = 1'b0;
      abort     = 1'b0;
      #12;
      tests_run++;
      if ({ap_start, done, cfg_ready, busy} !== REC_IDLE) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b, expected %b", {ap_start, done, cfg_ready, busy}, REC_IDLE);
      end
      tests_run++;
      if (beat_cnt !== '0) begin
         tests_failed++;
         $display("FAIL reset_beat_cnt: got %0d, expected 0", beat_cnt);
      end
      cfg_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      rec_t got, want;
      int   n;
      int   hi[NUM_PE];
      hi = '{default: 0};
      push_job(3, '0, 0);
      sb.push_back(REC_IDLE);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         cfg_valid = (c == 0);
         cfg_beats = 16'd3;
         stall     = 1'b0;
         abort     = 1'b0;
         @(negedge clk);
         got  = {ap_start, done, cfg_ready, busy};
         want = sb.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL basic cycle %0d: got %b, expected %b", c, got, want);
         end
         for (int i = 0; i < NUM_PE; i++) hi[i] += int'(ap_start[i]);
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < NUM_PE; i++) begin
         tests_run++;
         if (hi[i] !== 3) begin
            tests_failed++;
            $display("FAIL basic_count pe%0d: got %0d, expected 3", i, hi[i]);
         end
      end
      tests_run++;
      if (beat_cnt !== 16'd3) begin
         tests_failed++;
         $display("FAIL basic_beat_cnt: got %0d, expected 3", beat_cnt);
      end
   endtask

   task automatic test_stall();
      // Stalls on cycles 2 and 5 inside the job, plus cycle 0 (IDLE) and 10 (DONE) which must be inert.
      localparam logic [63:0] SMASK = 64'h425;
      rec_t got, want;
      int   n;
      int   hi[NUM_PE];
      hi = '{default: 0};
      push_job(3, SMASK, 0);
      sb.push_back(REC_IDLE);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         cfg_valid = (c == 0);
         cfg_beats = 16'd3;
         stall     = SMASK[c];
         abort     = 1'b0;
         @(negedge clk);
         got  = {ap_start, done, cfg_ready, busy};
         want = sb.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL stall cycle %0d: got %b, expected %b", c, got, want);
         end
         if (c == 10) begin
            tests_run++;
            if (done !== 1'b1) begin
               tests_failed++;
               $display("FAIL stall_done_cycle: got done=%b at cycle 10, expected 1", done);
            end
         end
         for (int i = 0; i < NUM_PE; i++) hi[i] += int'(ap_start[i]);
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < NUM_PE; i++) begin
         tests_run++;
         if (hi[i] !== 3) begin
            tests_failed++;
            $display("FAIL stall_count pe%0d: got %0d, expected 3", i, hi[i]);
         end
      end
   endtask

   task automatic test_zero_beats();
      rec_t got, want;
      int   n;
      push_job(0, '0, 0);
      sb.push_back(REC_IDLE);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         cfg_valid = (c == 0);
         cfg_beats = 16'd0;
         stall     = 1'b0;
         abort     = 1'b0;
         @(negedge clk);
         got  = {ap_start, done, cfg_ready, busy};
         want = sb.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL zero cycle %0d: got %b, expected %b", c, got, want);
         end
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (beat_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL zero_beat_cnt: got %0d, expected 0", beat_cnt);
      end
   endtask

   task automatic test_abort();
      // Abort (with stall also high) at cycle 4; abort again at cycle 5 in IDLE must be ignored.
      rec_t got, want;
      int   n;
      push_job(10, '0, 4);
      push_job(2, '0, 0);
      sb.push_back(REC_IDLE);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         cfg_valid = (c == 0) || (c == 5);
         cfg_beats = (c < 5) ? 16'd10 : 16'd2;
         stall     = (c == 4);
         abort     = (c == 4) || (c == 5);
         @(negedge clk);
         got  = {ap_start, done, cfg_ready, busy};
         want = sb.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL abort cycle %0d: got %b, expected %b", c, got, want);
         end
         if (c == 5) begin
            tests_run++;
            if (beat_cnt !== 16'd3) begin
               tests_failed++;
               $display("FAIL abort_partial_cnt: got %0d, expected 3", beat_cnt);
            end
         end
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (beat_cnt !== 16'd2) begin
         tests_failed++;
         $display("FAIL abort_next_job_cnt: got %0d, expected 2", beat_cnt);
      end
   endtask

   task automatic test_reset_in_drain();
      rec_t got, want;
      int   n;
      push_job(3, '0, 0);
      for (int c = 0; c <= 5; c++) begin
         cfg_valid = (c == 0);
         cfg_beats = 16'd3;
         stall     = 1'b0;
         abort     = 1'b0;
         @(negedge clk);
         got  = {ap_start, done, cfg_ready, busy};
         want = sb.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL rst_drain cycle %0d: got %b, expected %b", c, got, want);
         end
         if (c < 5) begin
            @(posedge clk);
            #1;
         end
      end
      sb.delete();
      // Mid-cycle, away from any clock edge: the response must be asynchronous.
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if ({ap_start, done, cfg_ready, busy} !== REC_IDLE) begin
         tests_failed++;
         $display("FAIL rst_drain_async: got %b, expected %b", {ap_start, done, cfg_ready, busy}, REC_IDLE);
      end
      tests_run++;
      if (beat_cnt !== '0) begin
         tests_failed++;
         $display("FAIL rst_drain_beat_cnt: got %0d, expected 0", beat_cnt);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      push_job(2, '0, 0);
      sb.push_back(REC_IDLE);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         cfg_valid = (c == 0);
         cfg_beats = 16'd2;
         stall     = 1'b0;
         abort     = 1'b0;
         @(negedge clk);
         got  = {ap_start, done, cfg_ready, busy};
         want = sb.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL rst_fresh cycle %0d: got %b, expected %b", c, got, want);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      // cfg_valid stays high; job 1 (5 beats) spans cycles 0..10, job 2 is accepted at 11.
      rec_t got, want;
      int   n;
      push_job(5, '0, 0);
      push_job(2, '0, 0);
      sb.push_back(REC_IDLE);
      n = sb.size();
      for (int c = 0; c < n; c++) begin
         cfg_valid = (c < n - 1);
         cfg_beats = (c < 11) ? 16'd5 : 16'd2;
         stall     = 1'b0;
         abort     = 1'b0;
         @(negedge clk);
         got  = {ap_start, done, cfg_ready, busy};
         want = sb.pop_front();
         tests_run++;
         if (got !== want) begin
            tests_failed++;
            $display("FAIL b2b cycle %0d: got %b, expected %b", c, got, want);
         end
         if (c == 11) begin
            tests_run++;
            if (beat_cnt !== 16'd5) begin
               tests_failed++;
               $display("FAIL b2b_first_cnt: got %0d, expected 5", beat_cnt);
            end
         end
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (beat_cnt !== 16'd2) begin
         tests_failed++;
         $display("FAIL b2b_second_cnt: got %0d, expected 2", beat_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_beats();
      test_abort();
      test_reset_in_drain();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
